noc_congestion_controller: RTL
==============================

Name: noc_congestion_controller

Overview:
- Per-router controller that sets the switch allocator's congestion and QoS controls: throttle_level, global_flow_control, qos_enforcement_active and priority_boost.
- Samples input-buffer occupancy and switch grant activity over fixed windows.
- Runs a hysteretic congestion state machine once per window.
- All outputs are registered and drive the allocator directly.

Parameters:
- NUM_PORTS, 5: router ports.
- OCC_WIDTH, 4: per-port occupancy width (flits, 0..15).
- WINDOW, 16: sampling window in cycles; power of 2, at least 2.
- TH_MILD, 20: rise threshold on window-average total occupancy.
- TH_MOD, 35: rise threshold.
- TH_SEV, 50: rise threshold.
- TH_HALT, 65: rise threshold.
- HYST, 5: fall threshold for a level is (its rise threshold - HYST).
- DOWN_WINDOWS, 2: consecutive below-fall windows required to step down.
- HALT_MAX_WINDOWS, 4: maximum windows spent in HALT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- enable  in  1  controller enable.
- port_occupancy  in  NUM_PORTS*OCC_WIDTH  packed per-port buffer occupancy; port p at [p*OCC_WIDTH +: OCC_WIDTH].
- grant_valid  in  NUM_PORTS  switch grant issued per output port this cycle.
- throttle_level  out  2  to allocator.
- global_flow_control  out  1  to allocator.
- qos_enforcement_active  out  1  to allocator.
- priority_boost  out  2  to allocator.
- cc_state  out  3  current state encoding, for monitoring.
- window_avg  out  8  last computed window average.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
  - While rst=1, all outputs and internal state are 0 and the FSM is in NORMAL.
  - Reset mid-window discards the partial window.
- Sampling:
  - win_cnt counts 0..WINDOW-1 and wraps.
  - Each enabled cycle, acc += sum of all port occupancies (sum width 8 bits). acc width is 8+log2(WINDOW) and cannot overflow.
  - gcnt += popcount(grant_valid), saturating at 255.
- Window end (win_cnt==WINDOW-1):
  - The current cycle's sample is included.
  - avg = acc_total >> log2(WINDOW) (truncating) is registered into window_avg.
  - The FSM evaluates using this avg.
  - acc and gcnt restart from 0 on the next cycle.
  - Outputs change on the cycle after the window-end cycle and are otherwise stable.
- FSM states: NORMAL=0, MILD=1, MODERATE=2, SEVERE=3, HALT=4. Evaluation happens only at window end.
  - Rise: if avg is at least the rise threshold of the next level, move up exactly one level (no skipping); down_cnt=0.
  - Fall: if avg is below the current level's fall threshold, increment down_cnt. When down_cnt reaches DOWN_WINDOWS, move down one level and set down_cnt=0.
  - Otherwise down_cnt=0.
  - Rise has priority over fall.
  - HALT: halt_cnt increments each window. If halt_cnt reaches HALT_MAX_WINDOWS, force SEVERE and set halt_cnt=0, regardless of avg. This is livelock protection.
  - SEVERE is re-entered from HALT normally; HALT may re-enter on a later window.
- Output map:
  - throttle_level = 0/1/2/3/3 for states 0..4.
  - global_flow_control = (state==HALT).
  - qos_enforcement_active = (state!=NORMAL).
- priority_boost: 2-bit saturating counter, updated at window end.
  - +1 (saturating at 3) if acc_total>0 and gcnt==0, i.e. demand present with no service.
  - -1 (saturating at 0) if gcnt>0.
  - Hold otherwise.
- enable=0:
  - win_cnt, acc, gcnt, down_cnt and halt_cnt clear next cycle.
  - FSM returns to NORMAL and all outputs go to 0 next cycle.
  - Re-enable starts a fresh window at win_cnt=0.
- Simultaneous events: for a full-occupancy window, the rise rule still moves only one level per window.

Decomposition:
- Shared package noc_cc_pkg holds:
  - cc_state_t enum (3-bit);
  - default threshold localparams;
  - function occ_sum(), a packed-array adder.
- One sub-module, cc_window_accumulator: holds win_cnt, acc and gcnt; emits window_done, avg and gcnt_final.
- The FSM and boost logic stay in the top module.

Test Plan:
- Reset/idle: rst pulse, then all occupancy 0 for 3 windows -> every output 0, window_avg=0, state NORMAL.
- Step-up:
  - All ports at occupancy 5 (sum 25) -> after window 1 ends, state MILD, throttle_level=1, qos_enforcement_active=1.
  - Then sum 75 -> one level per window: MODERATE, SEVERE, HALT. global_flow_control=1 on the cycle after the fourth window end.
- HALT timeout: hold sum 75 -> after 4 windows in HALT, state SEVERE with global_flow_control=0; HALT re-entered on the next window end.
- Hysteresis:
  - From MILD, sum 16 (just above fall threshold 15) -> stays MILD indefinitely.
  - Sum 10 -> returns to NORMAL only after exactly 2 windows.
  - A single-window dip followed by 16 resets down_cnt.
- Starvation boost:
  - Occupancy 3, grant_valid=0 for 4 windows -> priority_boost 1,2,3,3.
  - One grant per window -> decrements to 0 over 3 windows.
- Enable/reset mid-window: in SEVERE at win_cnt=7, drop enable for 1 cycle (or assert rst) -> outputs 0 next cycle and the partial window is discarded. With avg 25 on the next full window, the state becomes MILD.

Source files
------------

// File: rtl/noc_cc_pkg.sv
// Shared types, default thresholds and the occupancy adder for the NoC
// congestion controller.
package noc_cc_pkg;

  typedef enum logic [2:0] {
    CC_NORMAL   = 3'd0,
    CC_MILD     = 3'd1,
    CC_MODERATE = 3'd2,
    CC_SEVERE   = 3'd3,
    CC_HALT     = 3'd4
  } cc_state_t;

  localparam int unsigned DEF_TH_MILD      = 20;
  localparam int unsigned DEF_TH_MOD       = 35;
  localparam int unsigned DEF_TH_SEV       = 50;
  localparam int unsigned DEF_TH_HALT      = 65;
  localparam int unsigned DEF_HYST         = 5;
  localparam int unsigned DEF_DOWN_WINDOWS = 2;
  localparam int unsigned DEF_HALT_MAX     = 4;

  // Widest packed occupancy vector the adder accepts; callers zero-extend.
  localparam int unsigned OCC_VEC_MAX = 128;

  function automatic logic [7:0] occ_sum(input logic [OCC_VEC_MAX-1:0] vec,
                                         input int unsigned nports,
                                         input int unsigned w);
    logic [OCC_VEC_MAX-1:0] mask;
    logic [7:0]             s;
    mask = ~({OCC_VEC_MAX{1'b1}} << w);
    s    = '0;
    for (int unsigned p = 0; p < nports; p++) begin
      s = s + 8'((vec >> (p * w)) & mask);
    end
    return s;
  endfunction

endpackage

// File: rtl/cc_window_accumulator.sv
// Accumulates total occupancy and grant count over a fixed window and
// presents the window result combinationally on the window-end cycle.
module cc_window_accumulator
  import noc_cc_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned OCC_WIDTH = 4,
  parameter int unsigned WINDOW    = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           enable_i,
  input  logic [NUM_PORTS*OCC_WIDTH-1:0] occ_i,
  input  logic [NUM_PORTS-1:0]           grant_i,
  output logic                           window_done_o,
  output logic [7:0]                     avg_o,
  output logic [7:0]                     gcnt_final_o,
  output logic                           acc_nonzero_o
);

  localparam int unsigned LOG2W = $clog2(WINDOW);
  localparam int unsigned ACC_W = 8 + LOG2W;

  logic [LOG2W-1:0] win_cnt_q, win_cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_total;
  logic [7:0]       gcnt_q, gcnt_d, gcnt_total, sample, pc;
  logic [8:0]       gsum;

  always_comb begin
    sample = occ_sum(OCC_VEC_MAX'(occ_i), NUM_PORTS, OCC_WIDTH);
    pc     = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      pc = pc + 8'(grant_i[p]);
    end
    // The current cycle's sample is folded in before the window result is taken.
    acc_total  = acc_q + ACC_W'(sample);
    gsum       = {1'b0, gcnt_q} + {1'b0, pc};
    gcnt_total = gsum[8] ? 8'hFF : gsum[7:0];

    window_done_o = enable_i && (win_cnt_q == LOG2W'(WINDOW - 1));
    avg_o         = 8'(acc_total >> LOG2W);
    gcnt_final_o  = gcnt_total;
    acc_nonzero_o = |acc_total;

    win_cnt_d = win_cnt_q + LOG2W'(1);
    acc_d     = acc_total;
    gcnt_d    = gcnt_total;
    if (!enable_i || window_done_o) begin
      win_cnt_d = '0;
      acc_d     = '0;
      gcnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win_cnt_q <= '0;
      acc_q     <= '0;
      gcnt_q    <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      acc_q     <= acc_d;
      gcnt_q    <= gcnt_d;
    end
  end

endmodule

// File: rtl/noc_congestion_controller.sv
// Per-router congestion controller: hysteretic level FSM and starvation
// boost evaluated once per sampling window, all outputs registered.
module noc_congestion_controller
  import noc_cc_pkg::*;
#(
  parameter int unsigned NUM_PORTS        = 5,
  parameter int unsigned OCC_WIDTH        = 4,
  parameter int unsigned WINDOW           = 16,
  parameter int unsigned TH_MILD          = DEF_TH_MILD,
  parameter int unsigned TH_MOD           = DEF_TH_MOD,
  parameter int unsigned TH_SEV           = DEF_TH_SEV,
  parameter int unsigned TH_HALT          = DEF_TH_HALT,
  parameter int unsigned HYST             = DEF_HYST,
  parameter int unsigned DOWN_WINDOWS     = DEF_DOWN_WINDOWS,
  parameter int unsigned HALT_MAX_WINDOWS = DEF_HALT_MAX
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [NUM_PORTS*OCC_WIDTH-1:0] port_occupancy,
  input  logic [NUM_PORTS-1:0]           grant_valid,
  output logic [1:0]                     throttle_level,
  output logic                           global_flow_control,
  output logic                           qos_enforcement_active,
  output logic [1:0]                     priority_boost,
  output logic [2:0]                     cc_state,
  output logic [7:0]                     window_avg
);

  logic       win_done, win_nz;
  logic [7:0] win_avg, win_gcnt;

  cc_window_accumulator #(
    .NUM_PORTS (NUM_PORTS),
    .OCC_WIDTH (OCC_WIDTH),
    .WINDOW    (WINDOW)
  ) u_acc (
    .clk_i         (clk),
    .rst_i         (rst),
    .enable_i      (enable),
    .occ_i         (port_occupancy),
    .grant_i       (grant_valid),
    .window_done_o (win_done),
    .avg_o         (win_avg),
    .gcnt_final_o  (win_gcnt),
    .acc_nonzero_o (win_nz)
  );

  cc_state_t  state_q, state_d, next_up, next_dn;
  logic [7:0] down_q, down_d, halt_q, halt_d, avg_q, avg_d;
  logic [1:0] boost_q, boost_d, thr_q, thr_d;
  logic       gfc_q, gfc_d, qos_q, qos_d, rise_ok, fall_ok;

  always_comb begin
    rise_ok = 1'b0;
    fall_ok = 1'b0;
    next_up = state_q;
    next_dn = state_q;
    unique case (state_q)
      CC_NORMAL:   begin rise_ok = win_avg >= 8'(TH_MILD); next_up = CC_MILD; end
      CC_MILD:     begin
        rise_ok = win_avg >= 8'(TH_MOD);        next_up = CC_MODERATE;
        fall_ok = win_avg < 8'(TH_MILD - HYST); next_dn = CC_NORMAL;
      end
      CC_MODERATE: begin
        rise_ok = win_avg >= 8'(TH_SEV);        next_up = CC_SEVERE;
        fall_ok = win_avg < 8'(TH_MOD - HYST);  next_dn = CC_MILD;
      end
      CC_SEVERE:   begin
        rise_ok = win_avg >= 8'(TH_HALT);       next_up = CC_HALT;
        fall_ok = win_avg < 8'(TH_SEV - HYST);  next_dn = CC_MODERATE;
      end
      CC_HALT:     begin fall_ok = win_avg < 8'(TH_HALT - HYST); next_dn = CC_SEVERE; end
      default:     ;
    endcase

    state_d = state_q;
    down_d  = down_q;
    halt_d  = halt_q;
    boost_d = boost_q;
    avg_d   = avg_q;
    if (!enable) begin
      state_d = CC_NORMAL;
      down_d  = '0;
      halt_d  = '0;
      boost_d = '0;
      avg_d   = '0;
    end else if (win_done) begin
      avg_d = win_avg;
      // HALT timeout overrides the avg-driven rules entirely.
      if (state_q == CC_HALT && halt_q == 8'(HALT_MAX_WINDOWS - 1)) begin
        state_d = CC_SEVERE;
        halt_d  = '0;
        down_d  = '0;
      end else begin
        if (state_q == CC_HALT) halt_d = halt_q + 8'd1;
        if (rise_ok) begin
          state_d = next_up;
          down_d  = '0;
        end else if (fall_ok) begin
          if (down_q == 8'(DOWN_WINDOWS - 1)) begin
            state_d = next_dn;
            down_d  = '0;
            halt_d  = '0;
          end else begin
            down_d = down_q + 8'd1;
          end
        end else begin
          down_d = '0;
        end
      end
      if (win_gcnt != 8'd0) begin
        if (boost_q != 2'd0) boost_d = boost_q - 2'd1;
      end else if (win_nz) begin
        if (boost_q != 2'd3) boost_d = boost_q + 2'd1;
      end
    end

    unique case (state_d)
      CC_MILD:     thr_d = 2'd1;
      CC_MODERATE: thr_d = 2'd2;
      CC_SEVERE:   thr_d = 2'd3;
      CC_HALT:     thr_d = 2'd3;
      default:     thr_d = 2'd0;
    endcase
    gfc_d = (state_d == CC_HALT);
    qos_d = (state_d != CC_NORMAL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CC_NORMAL;
      down_q  <= '0;
      halt_q  <= '0;
      boost_q <= '0;
      avg_q   <= '0;
      thr_q   <= '0;
      gfc_q   <= 1'b0;
      qos_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      down_q  <= down_d;
      halt_q  <= halt_d;
      boost_q <= boost_d;
      avg_q   <= avg_d;
      thr_q   <= thr_d;
      gfc_q   <= gfc_d;
      qos_q   <= qos_d;
    end
  end

  assign throttle_level         = thr_q;
  assign global_flow_control    = gfc_q;
  assign qos_enforcement_active = qos_q;
  assign priority_boost         = boost_q;
  assign cc_state               = state_q;
  assign window_avg             = avg_q;

endmodule
